// File: rtl/game_state_ctrl.sv
// Screen sequencer downstream of the main menu: debounces the encoder button,
// tracks MENU/PLAY/CREDITS/GAMEOVER and drives the screen-mux and menu handshakes.
module game_state_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CREDITS_FRAMES  = 600,
    parameter int unsigned GAMEOVER_FRAMES = 180
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       press,
    input  logic [2:0] menuSelect,
    input  logic       frame_tick,
    input  logic       game_over,
    output logic       showCredits,
    output logic       menu_active,
    output logic [1:0] screen_sel,
    output logic       game_start
);

    typedef enum logic [1:0] {
        ST_MENU     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_CREDITS  = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    localparam int unsigned     DB_W          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]     CREDITS_LAST  = 16'(CREDITS_FRAMES - 1);
    localparam logic [15:0]     GAMEOVER_LAST = 16'(GAMEOVER_FRAMES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_pulse_q, press_pulse_d;
    state_e          state_q, state_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            show_credits_q, show_credits_d;
    logic            menu_active_q, menu_active_d;
    logic [1:0]      screen_sel_q, screen_sel_d;
    logic            game_start_q, game_start_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted one, so any bounce back to the accepted level restarts it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        level_d       = level_q;
        db_cnt_d      = '0;
        press_pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d       = sync2_q;
                press_pulse_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MENU: begin
                if (press_pulse_q) begin
                    if (menuSelect == 3'd0)      state_d = ST_PLAY;
                    else if (menuSelect == 3'd1) state_d = ST_CREDITS;
                end
            end
            ST_PLAY: begin
                if (game_over) state_d = ST_GAMEOVER;
            end
            ST_CREDITS: begin
                if (press_pulse_q || (frame_tick && frame_cnt_q == CREDITS_LAST))
                    state_d = ST_MENU;
            end
            ST_GAMEOVER: begin
                if (press_pulse_q || (frame_tick && frame_cnt_q == GAMEOVER_LAST))
                    state_d = ST_MENU;
            end
        endcase

        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q)
            frame_cnt_d = '0;
        else if (frame_tick && (state_q == ST_CREDITS || state_q == ST_GAMEOVER))
            frame_cnt_d = frame_cnt_q + 16'd1;

        // NOTE: outputs decode state_d so their flops change on the same edge as state_q.
        show_credits_d = (state_d == ST_CREDITS);
        menu_active_d  = (state_d == ST_MENU);
        screen_sel_d   = state_d;
        game_start_d   = (state_q == ST_MENU) && (state_d == ST_PLAY);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            level_q        <= 1'b0;
            db_cnt_q       <= '0;
            press_pulse_q  <= 1'b0;
            state_q        <= ST_MENU;
            frame_cnt_q    <= '0;
            show_credits_q <= 1'b0;
            menu_active_q  <= 1'b1;
            screen_sel_q   <= 2'd0;
            game_start_q   <= 1'b0;
        end else begin
            sync1_q        <= press;
            sync2_q        <= sync1_q;
            level_q        <= level_d;
            db_cnt_q       <= db_cnt_d;
            press_pulse_q  <= press_pulse_d;
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            show_credits_q <= show_credits_d;
            menu_active_q  <= menu_active_d;
            screen_sel_q   <= screen_sel_d;
            game_start_q   <= game_start_d;
        end
    end

    assign showCredits = show_credits_q;
    assign menu_active = menu_active_q;
    assign screen_sel  = screen_sel_q;
    assign game_start  = game_start_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus random stimulus, every
// cycle compared against a behavioural model of the screen sequencer.
module tb_game_state_ctrl;

    localparam int D  = 4;
    localparam int CF = 3;
    localparam int GF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       press = 1'b0;
    logic [2:0] menuSelect = 3'd0;
    logic       frame_tick = 1'b0;
    logic       game_over = 1'b0;
    logic       showCredits;
    logic       menu_active;
    logic [1:0] screen_sel;
    logic       game_start;

    int n_checks = 0;
    int n_bad    = 0;

    // Behavioural model: screen number, ticks seen since entry, button history.
    int m_state = 0;
    int m_ticks = 0;
    bit m_acc   = 1'b0;
    bit m_pulse = 1'b0;
    bit m_gs    = 1'b0;
    bit hist[$];

    game_state_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CREDITS_FRAMES (CF),
        .GAMEOVER_FRAMES(GF)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .press      (press),
        .menuSelect (menuSelect),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .showCredits(showCredits),
        .menu_active(menu_active),
        .screen_sel (screen_sel),
        .game_start (game_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model advance for one clock edge, using the inputs the DUT sampled.
    task automatic model_edge(input bit p, input int s, input bit t, input bit g, input bit r);
        int  nxt;
        bit  all_diff;
        if (r) begin
            m_state = 0; m_ticks = 0; m_acc = 1'b0; m_pulse = 1'b0; m_gs = 1'b0;
            hist.delete();
            for (int i = 0; i <= D; i++) hist.push_back(1'b0);
            return;
        end
        nxt = m_state;
        case (m_state)
            0: if (m_pulse && s == 0) nxt = 1; else if (m_pulse && s == 1) nxt = 2;
            1: if (g) nxt = 3;
            2: if (m_pulse || (t && m_ticks + 1 == CF)) nxt = 0;
            3: if (m_pulse || (t && m_ticks + 1 == GF)) nxt = 0;
            default: nxt = 0;
        endcase
        m_gs = (m_state == 0 && nxt == 1);
        if (nxt != m_state) m_ticks = 0;
        else if (t && m_state >= 2) m_ticks++;
        m_state = nxt;
        // A level is accepted once D consecutive synchronized samples disagree with it.
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (hist[i] == m_acc) all_diff = 1'b0;
        if (all_diff) begin
            m_acc   = !m_acc;
            m_pulse = m_acc;
        end else begin
            m_pulse = 1'b0;
        end
        hist.push_back(p);
        void'(hist.pop_front());
    endtask

    task automatic step(input bit p, input int s, input bit t, input bit g, input bit r);
        press      = p;
        menuSelect = 3'(s);
        frame_tick = t;
        game_over  = g;
        reset      = r;
        @(posedge clk);
        model_edge(p, s, t, g, r);
        @(negedge clk);
        check("menu_active", menu_active, m_state == 0);
        check("showCredits", showCredits, m_state == 2);
        check("screen_sel", screen_sel, m_state);
        check("game_start", game_start, m_gs);
    endtask

    task automatic idle(input int n, input int s);
        for (int i = 0; i < n; i++) step(1'b0, s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_for(input int n, input int s);
        for (int i = 0; i < n; i++) step(1'b1, s, 1'b0, 1'b0, 1'b0);
        idle(8, s);
    endtask

    initial begin
        int gs_cnt;
        int gs_at;
        int hold_left;
        bit rp;

        step(1'b1, 0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("rst_menu_active", menu_active, 1);
        check("rst_screen_sel", screen_sel, 0);
        check("rst_showCredits", showCredits, 0);

        // Clean hold: one game_start, seven cycles after the rise.
        gs_cnt = 0; gs_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 0, 1'b0, 1'b0, 1'b0);
            if (game_start) begin gs_cnt++; gs_at = i; end
        end
        check("t1_gs_count", gs_cnt, 1);
        check("t1_gs_cycle", gs_at, 7);
        check("t1_sel_play", screen_sel, 1);
        check("t1_menu_off", menu_active, 0);
        idle(8, 0);

        // game_over and press pulse together in PLAY.
        for (int i = 1; i <= 8; i++) step(1'b1, 0, 1'b0, i == 7, 1'b0);
        check("t4_gameover", screen_sel, 3);
        idle(8, 0);
        check("t4_hold", screen_sel, 3);
        press_for(6, 0);
        check("t4_early_exit", screen_sel, 0);
        press_for(6, 0);
        check("t4_replay", screen_sel, 1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t4_go2", screen_sel, 3);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("t4_tick1", screen_sel, 3);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("t4_timeout", screen_sel, 0);

        // Bouncing button, then a clean press into credits.
        for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1, 1'b0, 1'b0, 1'b0);
        check("t2_bounce_menu", menu_active, 1);
        press_for(6, 1);
        check("t2_accept", screen_sel, 2);
        check("t3_credits", showCredits, 1);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(2, 1);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(1, 1);
        check("t3_hold", screen_sel, 2);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        check("t3_exit", showCredits, 0);
        check("t3_exit_sel", screen_sel, 0);

        // Invalid selection and stray game_over in MENU.
        press_for(6, 5);
        check("t5_invalid", screen_sel, 0);
        step(1'b0, 5, 1'b0, 1'b1, 1'b0);
        check("t5_go_ignored", menu_active, 1);

        // Reset mid-timeout discards tick progress.
        press_for(6, 1);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        check("t6_pre_reset", screen_sel, 2);
        step(1'b0, 1, 1'b0, 1'b0, 1'b1);
        check("t6_rst_menu", menu_active, 1);
        check("t6_rst_sel", screen_sel, 0);
        check("t6_rst_credits", showCredits, 0);
        press_for(6, 1);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        check("t6_still_credits", screen_sel, 2);
        step(1'b0, 1, 1'b1, 1'b0, 1'b0);
        check("t6_exit", screen_sel, 0);

        // Random traffic against the model.
        rp = 1'b0;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            int sel;
            if (hold_left == 0) begin
                rp = !rp;
                hold_left = $urandom_range(1, 9);
            end
            hold_left--;
            r = $urandom_range(0, 9);
            sel = (r < 4) ? 0 : (r < 8) ? 1 : $urandom_range(2, 7);
            step(rp, sel, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
